// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Purpose : Shared types and helpers for the sig_debounce_edge filter.
//           db_state_t : FSM state encoding (two idle and two check states)
//           db_idle()  : maps a settled level onto its idle state
// Rev     : 1.0  initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } db_state_t;

  function automatic db_state_t db_idle(input logic level);
    return level ? IDLE_HI : IDLE_LO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ctr.sv
`default_nettype none
// ============================================================================
// Module  : debounce_ctr
// Purpose : Stability counter for the debounce FSM. Loads 1 on start,
//           clears on clear, increments on inc, and flags terminal count.
// Ports   : clk, rstn     clock, synchronous active-low reset
//           i_start       load the counter with 1 (first stable sample seen)
//           i_clr         force the counter to 0
//           i_inc         increment by one
//           o_tc          counter equals TC_VAL
// Rev     : 1.0  initial release
// ============================================================================
module debounce_ctr #(
  parameter int CNT_W  = 16,
  parameter int TC_VAL = 999
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_start,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] c_tc = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] r_cnt;

  // The FSM stops incrementing at terminal count, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(1);
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tc = (r_cnt == c_tc);

endmodule
`default_nettype wire

// File: rtl/sig_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module  : sig_debounce_edge
// Purpose : Debounces a clk-synchronous 1-bit level. A new level is accepted
//           only after DEBOUNCE_CYC consecutive equal samples; emits a clean
//           level, single-cycle rise/fall pulses and a saturating count of
//           rejected candidate changes.
// Ports   : clk, rstn      clock, synchronous active-low reset
//           i_sig_sync     input level, already synchronised to clk
//           i_en           1 = filtering active, 0 = abort check / hold level
//           i_glitch_clr   clear o_glitch_cnt (wins over an increment)
//           o_level        debounced level
//           o_rise/o_fall  one-cycle pulses on accepted 0->1 / 1->0
//           o_busy         candidate change under check
//           o_glitch_cnt   rejected-change count, saturating
// Rev     : 1.0  initial release
// ============================================================================
module sig_debounce_edge
  import debounce_pkg::*;
#(
  parameter int   CNT_W        = 16,
  parameter int   DEBOUNCE_CYC = 1000,
  parameter logic INIT_LEVEL   = 1'b0,
  parameter int   GLITCH_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_sig_sync,
  input  logic                i_en,
  input  logic                i_glitch_clr,
  output logic                o_level,
  output logic                o_rise,
  output logic                o_fall,
  output logic                o_busy,
  output logic [GLITCH_W-1:0] o_glitch_cnt
);

  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > (2**CNT_W) - 1) begin : g_bad_debounce_cyc
    $error("sig_debounce_edge: DEBOUNCE_CYC out of range 2..2**CNT_W-1");
  end

  localparam logic [GLITCH_W-1:0] c_glitch_max = {GLITCH_W{1'b1}};

  db_state_t           r_state;
  db_state_t           w_next;
  logic                w_start;
  logic                w_clr;
  logic                w_inc;
  logic                w_tc;
  logic                w_rise;
  logic                w_fall;
  logic                w_glitch;
  logic                r_level;
  logic                r_rise;
  logic                r_fall;
  logic                r_busy;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  debounce_ctr #(
    .CNT_W  (CNT_W),
    .TC_VAL (DEBOUNCE_CYC - 1)
  ) u_ctr (
    .clk     (clk),
    .rstn    (rstn),
    .i_start (w_start),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= db_idle(INIT_LEVEL);
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    w_rise   = 1'b0;
    w_fall   = 1'b0;
    w_glitch = 1'b0;
    case (r_state)
      IDLE_LO: begin
        if (i_en && i_sig_sync) begin
          w_next  = CHK_HI;
          w_start = 1'b1;
        end
      end
      CHK_HI: begin
        if (!i_en) begin
          w_next = IDLE_LO;
          w_clr  = 1'b1;
        end else if (!i_sig_sync) begin
          w_next   = IDLE_LO;
          w_clr    = 1'b1;
          w_glitch = 1'b1;
        end else if (w_tc) begin
          // The accepting edge lands in IDLE, so it can never start a new check.
          w_next = IDLE_HI;
          w_clr  = 1'b1;
          w_rise = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      IDLE_HI: begin
        if (i_en && !i_sig_sync) begin
          w_next  = CHK_LO;
          w_start = 1'b1;
        end
      end
      CHK_LO: begin
        if (!i_en) begin
          w_next = IDLE_HI;
          w_clr  = 1'b1;
        end else if (i_sig_sync) begin
          w_next   = IDLE_HI;
          w_clr    = 1'b1;
          w_glitch = 1'b1;
        end else if (w_tc) begin
          w_next = IDLE_LO;
          w_clr  = 1'b1;
          w_fall = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      default: begin
        w_next = db_idle(INIT_LEVEL);
        w_clr  = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_level <= INIT_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_level <= (w_next == IDLE_HI) || (w_next == CHK_LO);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= (w_next == CHK_HI) || (w_next == CHK_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_glitch_cnt <= '0;
    end else if (i_glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != c_glitch_max)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign o_level      = r_level;
  assign o_rise       = r_rise;
  assign o_fall       = r_fall;
  assign o_busy       = r_busy;
  assign o_glitch_cnt = r_glitch_cnt;

endmodule
`default_nettype wire
